// File: rtl/core_pkg.sv
// core_pkg: shared widths, control encoding and result payload for the execute path
package core_pkg;
  localparam int Xlen = 64;
  localparam int RegAddrW = 5;
  typedef enum logic [1:0] {CtrlNone, CtrlBranch, CtrlJal, CtrlJalr} ctrl_e;
  typedef struct packed {
    logic [Xlen-1:0]     result;
    logic [RegAddrW-1:0] rd_addr;
    logic                rd_we;
    logic                exc;
  } ex_result_t;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: main output register plus one skid entry; ready_o comes straight from a flop
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  T     skid_q;
  logic skid_v;
  logic accept;
  logic pop;
  assign ready_o = !skid_v;
  assign accept = valid_i && ready_o;
  assign pop = valid_o && ready_i;
  // The skid entry only fills while the main register is held, so main never empties ahead of it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      skid_v  <= 1'b0;
      skid_q  <= '0;
    end else if (pop || !valid_o) begin
      valid_o <= skid_v || accept;
      data_o  <= skid_v ? skid_q : (accept ? data_i : data_o);
      skid_v  <= 1'b0;
    end else if (accept) begin
      skid_q <= data_i;
      skid_v <= 1'b1;
    end
  end
endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: post-ALU stage producing writeback beats, fetch redirects and the epoch tag
// Optional misaligned-target trap enabled by defining CORE_MISALIGN_TRAP_EN.
module ex_result_stage
  import core_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                epoch_i,
  input  ctrl_e               ctrl_i,
  input  logic [Xlen-1:0]     pc_i,
  input  logic [Xlen-1:0]     imm_i,
  input  logic [Xlen-1:0]     alu_res_i,
  input  logic                branch_take_i,
  input  logic [RegAddrW-1:0] rd_addr_i,
  input  logic                rd_we_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [Xlen-1:0]     result_o,
  output logic [RegAddrW-1:0] rd_addr_o,
  output logic                rd_we_o,
  output logic                exc_o,
  output logic                redirect_valid_o,
  output logic [Xlen-1:0]     redirect_pc_o,
  output logic                epoch_o
);
  logic            live;
  logic            taken;
  logic            trap;
  logic            redirect;
  logic [Xlen-1:0] target;
  ex_result_t      beat;
  ex_result_t      out;
  // Stale-epoch beats are still accepted so the upstream pipe drains, but go no further
  assign live = valid_i && ready_o && (epoch_i == epoch_o);
  assign taken = (ctrl_i == CtrlBranch && branch_take_i) || ctrl_i == CtrlJal || ctrl_i == CtrlJalr;
  assign target = ctrl_i == CtrlJalr ? {alu_res_i[Xlen-1:1], 1'b0} : pc_i + imm_i;
`ifdef CORE_MISALIGN_TRAP_EN
  assign trap = taken && target[1];
`else
  assign trap = 1'b0;
`endif
  assign redirect = live && taken && !trap;
  always_comb begin
    beat.result  = (ctrl_i == CtrlJal || ctrl_i == CtrlJalr) ? pc_i + Xlen'(4) : alu_res_i;
    beat.rd_addr = rd_addr_i;
    beat.rd_we   = rd_we_i && rd_addr_i != '0 && !trap;
    beat.exc     = trap;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      epoch_o          <= 1'b0;
    end else begin
      redirect_valid_o <= redirect;
      if (redirect) begin
        redirect_pc_o <= target;
        epoch_o       <= !epoch_o;
      end
    end
  end
  skid_buffer #(.T(ex_result_t)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (live),
    .ready_o (ready_o),
    .data_i  (beat),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out)
  );
  assign result_o  = out.result;
  assign rd_addr_o = out.rd_addr;
  assign rd_we_o   = out.rd_we;
  assign exc_o     = out.exc;
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: scoreboard bench with a behavioural reference model for ex_result_stage
module tb_ex_result_stage;
  import core_pkg::*;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        epoch_i = 1'b0;
  ctrl_e       ctrl_i = CtrlNone;
  logic [63:0] pc_i = '0;
  logic [63:0] imm_i = '0;
  logic [63:0] alu_res_i = '0;
  logic        branch_take_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [63:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        exc_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        epoch_o;

  ex_result_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .epoch_i(epoch_i),
    .ctrl_i(ctrl_i), .pc_i(pc_i), .imm_i(imm_i), .alu_res_i(alu_res_i),
    .branch_take_i(branch_take_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .exc_o(exc_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .epoch_o(epoch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0;
  int          nerr = 0;
  logic        m_epoch = 1'b0;
  int          occ = 0;
  logic        exp_rv = 1'b0;
  logic [63:0] exp_rpc = '0;
  logic        chk_rst = 1'b0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h (t=%0t)", n, act, req, $time);
    end
  endtask

  // Reference model: applies the stage rules to every handshake seen at the clock edge
  always @(posedge clk) begin
    logic        tk, trp;
    logic [63:0] tgt;
    exp_t        e;
    exp_rv = 1'b0;
    chk_rst = 1'b0;
    if (!rst_ni) begin
      q.delete();
      m_epoch = 1'b0;
      occ = 0;
      chk_rst = 1'b1;
    end else begin
      if (valid_i && ready_o && epoch_i == m_epoch) begin
        tk = (ctrl_i == CtrlBranch && branch_take_i) || ctrl_i == CtrlJal || ctrl_i == CtrlJalr;
        tgt = (ctrl_i == CtrlJalr) ? (alu_res_i & ~64'h1) : pc_i + imm_i;
        trp = 1'b0;
`ifdef CORE_MISALIGN_TRAP_EN
        trp = tk && tgt[1];
`endif
        e.res = (ctrl_i == CtrlJal || ctrl_i == CtrlJalr) ? pc_i + 64'd4 : alu_res_i;
        e.rd = rd_addr_i;
        e.we = rd_we_i && rd_addr_i != 5'd0 && !trp;
        e.exc = trp;
        q.push_back(e);
        occ++;
        if (tk && !trp) begin
          exp_rv = 1'b1;
          exp_rpc = tgt;
          m_epoch = ~m_epoch;
        end
      end
      if (valid_o && ready_i) occ--;
    end
  end

  // Monitor: compares the DUT outputs against the model mid-cycle
  always @(negedge clk) begin
    if (chk_rst) begin
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 1);
      chk("rst_epoch", epoch_o, 0);
      chk("rst_redirect_valid", redirect_valid_o, 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_rd_addr", rd_addr_o, 0);
      chk("rst_rd_we", rd_we_o, 0);
      chk("rst_exc", exc_o, 0);
    end else begin
      chk("ready", ready_o, occ < 2);
      chk("epoch", epoch_o, m_epoch);
      chk("redirect_valid", redirect_valid_o, exp_rv);
      if (exp_rv) chk("redirect_pc", redirect_pc_o, exp_rpc);
      chk("valid", valid_o, q.size() != 0);
      if (valid_o && q.size() != 0) begin
        chk("result", result_o, q[0].res);
        chk("rd_addr", rd_addr_o, q[0].rd);
        chk("rd_we", rd_we_o, q[0].we);
        chk("exc", exc_o, q[0].exc);
        if (ready_i) void'(q.pop_front());
      end
    end
  end

  task automatic send(input ctrl_e c, input logic [63:0] pc, input logic [63:0] imm,
                      input logic [63:0] alu, input logic bt, input logic [4:0] rd,
                      input logic we, input logic ep);
    int   n = 0;
    logic acc;
    valid_i = 1'b1; ctrl_i = c; pc_i = pc; imm_i = imm; alu_res_i = alu;
    branch_take_i = bt; rd_addr_i = rd; rd_we_i = we; epoch_i = ep;
    do begin
      acc = ready_o;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("send_accept", acc, 1);
    valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    send(CtrlNone, 64'h0, 64'h0, 64'h1234, 1'b0, 5'd5, 1'b1, m_epoch);
    send(CtrlBranch, 64'h100, 64'h20, 64'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    send(CtrlNone, 64'h0, 64'h0, 64'hdead, 1'b0, 5'd7, 1'b1, 1'b0);
    send(CtrlJal, 64'h200, 64'h40, 64'h0, 1'b0, 5'd8, 1'b1, 1'b0);
    send(CtrlJalr, 64'h400, 64'h0, 64'h2003, 1'b0, 5'd1, 1'b1, m_epoch);
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 6; i++) send(CtrlNone, 64'h0, 64'h0, 64'h100 + 64'(i), 1'b0, 5'(i + 10), 1'b1, m_epoch);
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    send(CtrlBranch, 64'h300, 64'h10, 64'h55, 1'b0, 5'd0, 1'b1, m_epoch);
    send(CtrlBranch, 64'h500, 64'h8, 64'h0, 1'b1, 5'd3, 1'b1, m_epoch);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      valid_i = $urandom_range(0, 3) != 0;
      epoch_i = ($urandom_range(0, 7) == 0) ? ~m_epoch : m_epoch;
      ctrl_i = ctrl_e'($urandom_range(0, 3));
      pc_i = {$urandom(), $urandom()};
      imm_i = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 255)) : {$urandom(), $urandom()};
      alu_res_i = {$urandom(), $urandom()};
      branch_take_i = $urandom_range(0, 1) != 0;
      rd_addr_i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd_we_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("drain_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Pipeline stage directly downstream of the ALU in the execute path.
- Consumes the ALU result and branch decision, plus decoded control from the execute stage.
- Produces the register writeback value, taken control-transfer redirects to fetch, and a registered valid/ready beat to the memory/writeback stage.
- Drops wrong-path instructions using a 1-bit epoch, and contains a 2-entry skid buffer so `ready_o` is registered.

Parameters:
- Xlen, core_pkg::Xlen (64): datapath width; not overridable per instance.
- RegAddrW, 5: destination register index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat
- epoch_i  in  1  epoch tag carried by the upstream beat
- ctrl_i  in  ctrl_e  CtrlNone / CtrlBranch / CtrlJal / CtrlJalr
- pc_i  in  Xlen  instruction PC
- imm_i  in  Xlen  sign-extended immediate
- alu_res_i  in  Xlen  ALU res_o
- branch_take_i  in  1  ALU branch_take_o; ignored unless ctrl_i==CtrlBranch
- rd_addr_i  in  RegAddrW  destination register
- rd_we_i  in  1  destination write enable
- valid_o  out  1  downstream beat valid
- ready_i  in  1  downstream ready
- result_o  out  Xlen  writeback data
- rd_addr_o  out  RegAddrW  destination register
- rd_we_o  out  1  write enable; forced 0 when rd_addr is 0
- exc_o  out  1  misaligned-target exception flag (see Optional Feature)
- redirect_valid_o  out  1  one-cycle redirect pulse to fetch
- redirect_pc_o  out  Xlen  redirect target
- epoch_o  out  1  current epoch, for fetch tagging

Behaviour:
- Reset, synchronous active-low:
  - valid_o=0, redirect_valid_o=0, epoch_o=0, ready_o=1, skid empty.
  - result_o/rd_addr_o/redirect_pc_o = 0; exc_o=0, rd_we_o=0.
  - Any in-flight beat and any pending redirect are discarded.
- Accept: valid_i && ready_o.
- Stale beat (epoch_i != epoch_o):
  - Accepted and discarded.
  - Never reaches the buffer; causes no redirect.
- Live beat computation:
  - taken = (ctrl==CtrlBranch && branch_take_i) || ctrl==CtrlJal || ctrl==CtrlJalr.
  - target = pc_i+imm_i for Branch/Jal; {alu_res_i[Xlen-1:1],1'b0} for Jalr.
  - result = pc_i+4 for Jal/Jalr; alu_res_i otherwise. All sums are modulo 2^Xlen.
- Redirect:
  - If a live beat is taken, in the next cycle redirect_valid_o=1 for exactly one cycle, with redirect_pc_o=target.
  - epoch_o toggles on the same edge.
  - The redirect is independent of downstream stalls.
- Epoch window:
  - Upstream beats accepted in the acceptance cycle or later carry the old epoch until fetch re-tags, so they are dropped.
  - A second taken in the cycle right after a redirect is therefore impossible.
- Output buffer:
  - Main register plus one skid entry.
  - ready_o = !skid_valid (registered).
  - Beat order is preserved; zero bubbles at full throughput.
  - When valid_o && !ready_i, the output holds stable.
- Latency: 1 cycle from acceptance to valid_o when the buffer is empty.
- Simultaneous events:
  - Accept plus downstream pop in the same cycle: occupancy is unchanged.
  - Skid full: ready_o=0; valid_i is ignored.

Optional Feature:
- Macro: CORE_MISALIGN_TRAP_EN.
- Defined:
  - A taken target with target[1]==1 causes no redirect and no epoch toggle.
  - The beat is forwarded with exc_o=1 and rd_we_o=0.
- Undefined:
  - exc_o is tied 0; target[1] is not checked.

Decomposition:
- core_pkg:
  - ctrl_e enum (2 bits).
  - ex_result_t struct {result, rd_addr, rd_we, exc}.
- Sub-module: skid_buffer, parameterized on payload type, containing the main and skid registers and the handshake.
- Redirect, epoch and target logic stay in ex_result_stage.

Test Plan:
- ALU op, ctrl=None, alu_res=0x1234, rd=5, ready_i=1 -> next cycle valid_o=1, result_o=0x1234, rd_we_o=1, no redirect.
- Branch pc=0x100, imm=0x20, branch_take=1, epoch 0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x120, epoch_o=1; two following beats tagged epoch 0 are accepted and never appear on valid_o.
- Jalr alu_res=0x2003, pc=0x400, rd=1 -> redirect_pc_o=0x2002, result_o=0x404. With CORE_MISALIGN_TRAP_EN: no redirect, exc_o=1, rd_we_o=0.
- Stream of 6 live beats with ready_i low for 3 cycles mid-stream -> ready_o drops after 2 buffered beats, all 6 emerge in order, none duplicated.
- Branch with branch_take=0 and rd=0 -> no redirect, epoch unchanged, rd_we_o=0.
- rst_ni low for one cycle the cycle after a taken branch is accepted -> redirect_valid_o=0, valid_o=0, epoch_o=0, ready_o=1.
